// File: rtl/atm_unit.sv
// atm_unit: transaction engine for a 10-account automated teller.
// Holds an on-chip table of PINs and balances. Each transaction
// authenticates an account number and PIN, then performs a balance
// inquiry, withdrawal, deposit or PIN change. Every transaction takes
// exactly four clock edges, on both the pass and the fail path.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset (restores the account table)
//   operation 3 = inquiry, 4 = withdraw, 5 = deposit, 6 = change PIN
//   acc_num   account number, valid range 1..10
//   pin       entered PIN (binary value)
//   newPin    replacement PIN for operation 6
//   amount    unsigned amount for withdraw/deposit
//   language  display-side selection, unused by the datapath
//   balance   registered balance after the last transaction (0 on failure)
//   success   registered, 1 when the last transaction completed
//   state     current FSM state encoding
module atm_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  operation,
    input  logic [3:0]  acc_num,
    input  logic [15:0] pin,
    input  logic [15:0] newPin,
    input  logic [31:0] amount,
    input  logic        language,
    output logic [31:0] balance,
    output logic        success,
    output logic [2:0]  state
);

    // Terminal-state encodings equal the operation codes, so the PIN
    // check can jump straight to the state named by the operation.
    typedef enum logic [2:0] {
        S_ACC   = 3'd0,
        S_PIN   = 3'd1,
        S_ERROR = 3'd2,
        S_BAL   = 3'd3,
        S_WDR   = 3'd4,
        S_DEP   = 3'd5,
        S_CHG   = 3'd6,
        S_IDLE  = 3'd7
    } state_t;

    state_t      cur_state, next_state;

    logic [2:0]  op_q;
    logic [3:0]  acc_q;
    logic [15:0] pin_q;
    logic [15:0] new_pin_q;
    logic [31:0] amount_q;
    logic        acc_ok;

    logic [15:0] pin_table [10];
    logic [31:0] bal_table [10];

    logic [3:0]  idx;
    logic        acc_valid;
    logic [15:0] stored_pin;
    logic [31:0] stored_bal;
    logic [32:0] dep_sum;

    logic        load_result;
    logic [31:0] balance_next;
    logic        success_next;
    logic        write_bal;
    logic        write_pin;
    logic [31:0] bal_wdata;

    // The language select only matters to the display logic downstream.
    logic        unused_language;
    assign unused_language = language;

    function automatic logic [15:0] default_pin(input int i);
        case (i)
            0:       default_pin = 16'd1234;
            1:       default_pin = 16'd2345;
            2:       default_pin = 16'd3456;
            3:       default_pin = 16'd4567;
            4:       default_pin = 16'd5678;
            5:       default_pin = 16'd6789;
            6:       default_pin = 16'd7890;
            7:       default_pin = 16'd8901;
            8:       default_pin = 16'd9012;
            9:       default_pin = 16'd7123;
            default: default_pin = 16'd0;
        endcase
    endfunction

    assign state     = cur_state;
    assign idx       = acc_q - 4'd1;
    assign acc_valid = (acc_q >= 4'd1) && (acc_q <= 4'd10);

    // Table reads are gated by acc_ok so an invalid account never
    // indexes past the end of the table.
    assign stored_pin = acc_ok ? pin_table[idx] : 16'd0;
    assign stored_bal = acc_ok ? bal_table[idx] : 32'd0;
    assign dep_sum    = {1'b0, stored_bal} + {1'b0, amount_q};

    // Next-state and result computation. Results and table writes are
    // produced while in a terminal state and registered on the edge
    // that returns to IDLE.
    always_comb begin
        next_state   = cur_state;
        load_result  = 1'b0;
        balance_next = 32'd0;
        success_next = 1'b0;
        write_bal    = 1'b0;
        write_pin    = 1'b0;
        bal_wdata    = stored_bal;
        case (cur_state)
            S_IDLE: next_state = S_ACC;
            S_ACC:  next_state = S_PIN;
            S_PIN: begin
                if (acc_ok && (stored_pin == pin_q) &&
                    (op_q >= 3'd3) && (op_q <= 3'd6))
                    next_state = state_t'(op_q);
                else
                    next_state = S_ERROR;
            end
            S_BAL: begin
                next_state   = S_IDLE;
                load_result  = 1'b1;
                balance_next = stored_bal;
                success_next = 1'b1;
            end
            S_WDR: begin
                next_state  = S_IDLE;
                load_result = 1'b1;
                if (amount_q <= stored_bal) begin
                    bal_wdata    = stored_bal - amount_q;
                    write_bal    = 1'b1;
                    balance_next = bal_wdata;
                    success_next = 1'b1;
                end
            end
            S_DEP: begin
                next_state  = S_IDLE;
                load_result = 1'b1;
                if (!dep_sum[32]) begin
                    bal_wdata    = dep_sum[31:0];
                    write_bal    = 1'b1;
                    balance_next = bal_wdata;
                    success_next = 1'b1;
                end
            end
            S_CHG: begin
                next_state   = S_IDLE;
                load_result  = 1'b1;
                write_pin    = 1'b1;
                balance_next = stored_bal;
                success_next = 1'b1;
            end
            S_ERROR: begin
                next_state  = S_IDLE;
                load_result = 1'b1;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // State register, input latches, result registers and account table.
    // Reset puts every account back to its default PIN and balance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= S_IDLE;
            op_q      <= 3'd0;
            acc_q     <= 4'd0;
            pin_q     <= 16'd0;
            new_pin_q <= 16'd0;
            amount_q  <= 32'd0;
            acc_ok    <= 1'b0;
            balance   <= 32'd0;
            success   <= 1'b0;
            for (int i = 0; i < 10; i++) begin
                pin_table[i] <= default_pin(i);
                bal_table[i] <= 32'(1000 * (i + 1));
            end
        end else begin
            cur_state <= next_state;
            if (cur_state == S_IDLE) begin
                op_q      <= operation;
                acc_q     <= acc_num;
                pin_q     <= pin;
                new_pin_q <= newPin;
                amount_q  <= amount;
            end
            if (cur_state == S_ACC)
                acc_ok <= acc_valid;
            if (load_result) begin
                balance <= balance_next;
                success <= success_next;
            end
            if (write_bal)
                bal_table[idx] <= bal_wdata;
            if (write_pin)
                pin_table[idx] <= new_pin_q;
        end
    end

endmodule

// File: tb/tb_atm_unit.sv
// tb_atm_unit: self-checking bench for atm_unit. A table of directed
// transactions with hand-computed results, a few multi-cycle sequences
// (state trace, mid-transaction reset, input changes in flight), then
// randomized transactions checked against a behavioural account model.
module tb_atm_unit;

    logic        clk;
    logic        rst;
    logic [2:0]  operation;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic [15:0] newPin;
    logic [31:0] amount;
    logic        language;
    logic [31:0] balance;
    logic        success;
    logic [2:0]  state;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  acc;
        logic [15:0] pin;
        logic [15:0] new_pin;
        logic [31:0] amt;
        logic [31:0] exp_bal;
        logic        exp_succ;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model of the account table, indexed by account number.
    logic [15:0] m_pin [1:10];
    logic [31:0] m_bal [1:10];
    int default_pins [10] = '{1234, 2345, 3456, 4567, 5678, 6789, 7890, 8901, 9012, 7123};

    atm_unit dut (
        .clk       (clk),
        .rst       (rst),
        .operation (operation),
        .acc_num   (acc_num),
        .pin       (pin),
        .newPin    (newPin),
        .amount    (amount),
        .language  (language),
        .balance   (balance),
        .success   (success),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic model_reset();
        for (int a = 1; a <= 10; a++) begin
            m_pin[a] = 16'(default_pins[a - 1]);
            m_bal[a] = 32'(1000 * a);
        end
    endtask

    // Applies the account rules to the model and returns the expected outputs.
    task automatic model_apply(input logic [2:0] op, input logic [3:0] acc, input logic [15:0] p,
                               input logic [15:0] np, input logic [31:0] amt,
                               output logic [31:0] eb, output logic es);
        longint sum;
        eb = 32'd0;
        es = 1'b0;
        if (acc >= 1 && acc <= 10 && p == m_pin[acc] && op >= 3 && op <= 6) begin
            case (op)
                3'd3: begin eb = m_bal[acc]; es = 1'b1; end
                3'd4: if (amt <= m_bal[acc]) begin
                          m_bal[acc] = m_bal[acc] - amt;
                          eb = m_bal[acc]; es = 1'b1;
                      end
                3'd5: begin
                          sum = longint'(m_bal[acc]) + longint'(amt);
                          if (sum < 64'h1_0000_0000) begin
                              m_bal[acc] = 32'(sum);
                              eb = m_bal[acc]; es = 1'b1;
                          end
                      end
                default: begin m_pin[acc] = np; eb = m_bal[acc]; es = 1'b1; end
            endcase
        end
    endtask

    // Called at a falling edge: drives one transaction, waits the four
    // edges it takes and samples the results at the next falling edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [3:0] acc, input logic [15:0] p,
                                 input logic [15:0] np, input logic [31:0] amt,
                                 output logic [31:0] got_bal, output logic got_succ);
        operation = op;
        acc_num   = acc;
        pin       = p;
        newPin    = np;
        amount    = amt;
        language  = 1'($urandom_range(0, 1));
        repeat (4) @(negedge clk);
        got_bal  = balance;
        got_succ = success;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got_bal, input logic got_succ,
                               input logic [31:0] exp_bal, input logic exp_succ);
        check_val({name, " balance"}, got_bal, exp_bal);
        check_val({name, " success"}, {31'd0, got_succ}, {31'd0, exp_succ});
    endtask

    task automatic add_vec(input logic [2:0] op, input logic [3:0] acc, input logic [15:0] p,
                           input logic [15:0] np, input logic [31:0] amt,
                           input logic [31:0] eb, input logic es);
        vec_t v;
        v.op = op; v.acc = acc; v.pin = p; v.new_pin = np; v.amt = amt;
        v.exp_bal = eb; v.exp_succ = es;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] gb, eb;
        logic        gs, es;
        logic [2:0]  op;
        logic [3:0]  acc;
        logic [15:0] p;
        logic [31:0] amt;
        int          r;

        // Directed table, expected values worked out by hand from defaults.
        for (int n = 1; n <= 10; n++)
            add_vec(3'd3, 4'(n), 16'(default_pins[n - 1]), 16'd0, 32'd0, 32'(1000 * n), 1'b1);
        for (int n = 1; n <= 10; n++) begin
            add_vec(3'd5, 4'(n), 16'(default_pins[n - 1]), 16'd0, 32'd1000, 32'(1000 * n + 1000), 1'b1);
            add_vec(3'd4, 4'(n), 16'(default_pins[n - 1]), 16'd0, 32'd500, 32'(1000 * n + 500), 1'b1);
        end
        add_vec(3'd4, 4'd1, 16'd1235, 16'd0, 32'd500, 32'd0, 1'b0);
        add_vec(3'd3, 4'd1, 16'd1234, 16'd0, 32'd0, 32'd1500, 1'b1);
        add_vec(3'd6, 4'd1, 16'd1234, 16'd5678, 32'd0, 32'd1500, 1'b1);
        add_vec(3'd3, 4'd1, 16'd1234, 16'd0, 32'd0, 32'd0, 1'b0);
        add_vec(3'd3, 4'd1, 16'd5678, 16'd0, 32'd0, 32'd1500, 1'b1);
        add_vec(3'd4, 4'd2, 16'd2345, 16'd0, 32'd2501, 32'd0, 1'b0);
        add_vec(3'd4, 4'd2, 16'd2345, 16'd0, 32'd2500, 32'd0, 1'b1);
        add_vec(3'd3, 4'd0, 16'd1234, 16'd0, 32'd0, 32'd0, 1'b0);
        add_vec(3'd3, 4'd11, 16'd1234, 16'd0, 32'd0, 32'd0, 1'b0);
        add_vec(3'd2, 4'd4, 16'd4567, 16'd0, 32'd0, 32'd0, 1'b0);
        add_vec(3'd7, 4'd4, 16'd4567, 16'd0, 32'd0, 32'd0, 1'b0);
        add_vec(3'd5, 4'd3, 16'd3456, 16'd0, 32'hFFFF_FFFF, 32'd0, 1'b0);
        add_vec(3'd5, 4'd3, 16'd3456, 16'd0, 32'hFFFF_FFFF - 32'd3500, 32'hFFFF_FFFF, 1'b1);
        add_vec(3'd5, 4'd3, 16'd3456, 16'd0, 32'd1, 32'd0, 1'b0);
        add_vec(3'd3, 4'd3, 16'd3456, 16'd0, 32'd0, 32'hFFFF_FFFF, 1'b1);

        // Reset held low across several edges.
        rst = 1'b0;
        operation = 3'd3; acc_num = 4'd1; pin = 16'd1234; newPin = 16'd0; amount = 32'd0; language = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("reset state", {29'd0, state}, 32'd7);
        checkOutput("reset", balance, success, 32'd0, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].acc, vecs[i].pin, vecs[i].new_pin, vecs[i].amt, gb, gs);
            model_apply(vecs[i].op, vecs[i].acc, vecs[i].pin, vecs[i].new_pin, vecs[i].amt, eb, es);
            checkOutput($sformatf("vec%0d", i), gb, gs, vecs[i].exp_bal, vecs[i].exp_succ);
        end

        // State trace through the fail path (wrong PIN on account 5).
        operation = 3'd4; acc_num = 4'd5; pin = 16'd1111; amount = 32'd10;
        @(negedge clk); check_val("trace acc", {29'd0, state}, 32'd0);
        @(negedge clk); check_val("trace pin", {29'd0, state}, 32'd1);
        @(negedge clk); check_val("trace error", {29'd0, state}, 32'd2);
        @(negedge clk); check_val("trace idle", {29'd0, state}, 32'd7);
        checkOutput("trace result", balance, success, 32'd0, 1'b0);

        // State trace through the pass path (deposit lands in state 5).
        operation = 3'd5; acc_num = 4'd6; pin = 16'd6789; amount = 32'd1;
        model_apply(3'd5, 4'd6, 16'd6789, 16'd0, 32'd1, eb, es);
        @(negedge clk); @(negedge clk); @(negedge clk);
        check_val("trace dep", {29'd0, state}, 32'd5);
        @(negedge clk);
        checkOutput("trace dep result", balance, success, eb, es);

        // Inputs changed after sampling must not affect the transaction.
        operation = 3'd3; acc_num = 4'd7; pin = 16'd7890; amount = 32'd0;
        model_apply(3'd3, 4'd7, 16'd7890, 16'd0, 32'd0, eb, es);
        @(negedge clk);
        operation = 3'd2; acc_num = 4'd0; pin = 16'd0; amount = 32'd99;
        repeat (3) @(negedge clk);
        checkOutput("in-flight change", balance, success, eb, es);

        // Reset in the middle of a withdrawal aborts it and restores defaults.
        operation = 3'd4; acc_num = 4'd8; pin = m_pin[8]; amount = 32'd100;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_val("mid reset state", {29'd0, state}, 32'd7);
        checkOutput("mid reset", balance, success, 32'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        applyStimulus(3'd3, 4'd8, 16'd8901, 16'd0, 32'd0, gb, gs);
        checkOutput("after reset acc8", gb, gs, 32'd8000, 1'b1);
        applyStimulus(3'd3, 4'd3, 16'd3456, 16'd0, 32'd0, gb, gs);
        checkOutput("after reset acc3", gb, gs, 32'd3000, 1'b1);

        // Randomized transactions against the model.
        for (int i = 0; i < 80; i++) begin
            r   = int'($urandom_range(0, 9));
            op  = (r < 8) ? 3'(3 + (r % 4)) : ((r == 8) ? 3'd2 : 3'd7);
            acc = 4'($urandom_range(0, 11));
            if (acc >= 1 && acc <= 10 && $urandom_range(0, 3) != 0)
                p = m_pin[acc];
            else
                p = 16'($urandom);
            r = int'($urandom_range(0, 3));
            if (r == 0)
                amt = $urandom;
            else if (r == 1 && acc >= 1 && acc <= 10)
                amt = m_bal[acc];
            else
                amt = 32'($urandom_range(0, 3000));
            applyStimulus(op, acc, p, 16'($urandom_range(0, 9999)), amt, gb, gs);
            model_apply(op, acc, p, newPin, amt, eb, es);
            checkOutput($sformatf("rand%0d", i), gb, gs, eb, es);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
